param_stream_loader: RTL and testbench
======================================

// Module: param_stream_loader
// PURPOSE
//  Generic UART-fed parameter loader, successor to the fixed-map weight loader.
//  Receives a framed byte stream: sync word, payload, then a 16-bit checksum.
//  Slices the payload into NUM_SEG segments described by parameters.
//  Emits one element write per segment entry on a single generic write port.
//  Sits between uart_rx and the conv/dense weight and bias RAMs; wr_seg selects the RAM.
// PARAMETERS
//  NUM_SEG     6        number of payload segments, streamed in index order
//  SEG_LEN     {10,8000,32,4608,16,144}  packed 16b per seg (seg0 = LSBs); element count
//  SEG_BYTES   {4,1,4,1,4,1}             packed 3b per seg; bytes/element, 1..4, little-endian
//  SEG_BASE    {0,0,16,144,0,0}          packed ADDR_W per seg; dest address of element 0
//  ADDR_W      13       write address width
//  TIMEOUT_CYC 1000000  max idle clk cycles between bytes once framing has started
//  SYNC0/SYNC1 8'hA5/8'h5A  frame sync bytes
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous active-high reset
//  rx_data       in   8       received byte, valid when rx_ready=1
//  rx_ready      in   1       one-cycle strobe per byte
//  wr_en         out  1       one-cycle element write strobe
//  wr_seg        out  clog2(NUM_SEG)  segment index of the current write
//  wr_addr       out  ADDR_W  SEG_BASE[seg] + element index
//  wr_data       out  32      assembled element; sign-extended when bytes<4
//  busy          out  1       high in SYNC/LOAD/CHECK states
//  transfer_done out  1       frame received and checksum good; held
//  error         out  1       frame aborted; held
//  err_code      out  2       0 none, 1 timeout, 2 checksum mismatch
//  progress      out  16      payload bytes received, saturating (LED display)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters, checksum and assembly register cleared.
//  rst mid-frame aborts with no further writes.
//  FSM states:
//   IDLE : rx SYNC0 -> SYNC; any other byte is ignored.
//   SYNC : rx SYNC1 -> LOAD; rx SYNC0 -> stay in SYNC; any other byte -> IDLE.
//   LOAD : each byte is added into csum (16b, mod 2^16) and shifted into element byte k.
//          k = SEG_BYTES[seg]-1 completes an element:
//           wr_en=1 on the next clk, with wr_seg/wr_addr/wr_data stable that cycle.
//           wr_en is low on all other cycles.
//          Element count reaching SEG_LEN[seg] advances seg.
//          Segments with SEG_LEN=0 are skipped without consuming bytes.
//          After the last byte of the last segment -> CHECK.
//   CHECK: two bytes, low byte first, form the trailer.
//          Trailer == csum -> DONE; otherwise -> ERR with err_code=2.
//   DONE : transfer_done=1, busy=0.
//   ERR  : error=1, busy=0.
//   From DONE or ERR, rx SYNC0 clears done, error and err_code, then -> SYNC (new frame).
//  Sync bytes and trailer bytes are excluded from csum and from progress.
//  Timeout: idle counter is cleared on every rx_ready and runs in SYNC/LOAD/CHECK only.
//   At TIMEOUT_CYC -> ERR with err_code=1; a partially assembled element is discarded.
//  Writes are issued before checksum verification.
//   Consumers must gate use of the loaded data on transfer_done=1 and error=0.
//  rx_ready is honoured on every cycle, including the cycle wr_en is high.
//   Back-to-back strobes are legal.
//  progress saturates at 16'hFFFF and is cleared at SYNC1 acceptance.
// TESTING
//  1. Default map, A5 5A, 12984 payload bytes, correct csum
//     -> 12810 writes, transfer_done=1, error=0.
//  2. Seg1 bytes 78 56 34 12 -> wr_seg=1, wr_addr=0, wr_data=32'h12345678.
//     Seg0 byte FF -> wr_data=32'hFFFFFFFF.
//  3. Prefix 00 A5 00 A5 A5 5A before a good frame
//     -> no writes from the prefix; frame loads normally.
//  4. Good payload with trailer csum^16'h0001
//     -> error=1, err_code=2, transfer_done=0.
//  5. Stop after 500 payload bytes, idle TIMEOUT_CYC cycles -> err_code=1, busy=0.
//     A fresh frame then completes with transfer_done=1.
//  6. rst pulse mid-LOAD -> all outputs 0 next cycle, no writes.
//     A following full frame succeeds, with writes starting at seg0 addr0.

Source files
------------

// File: rtl/param_stream_loader.sv
// param_stream_loader: framed byte-stream parameter loader driving a generic segment/address write port
module param_stream_loader #(
    parameter int NUM_SEG = 6,
    parameter int ADDR_W = 13,
    parameter logic [NUM_SEG*16-1:0] SEG_LEN = {16'd10, 16'd8000, 16'd32, 16'd4608, 16'd16, 16'd144},
    parameter logic [NUM_SEG*3-1:0] SEG_BYTES = {3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1},
    parameter logic [NUM_SEG*ADDR_W-1:0] SEG_BASE = {ADDR_W'(0), ADDR_W'(0), ADDR_W'(16), ADDR_W'(144), ADDR_W'(0), ADDR_W'(0)},
    parameter int TIMEOUT_CYC = 1000000,
    parameter logic [7:0] SYNC0 = 8'hA5,
    parameter logic [7:0] SYNC1 = 8'h5A,
    localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              wr_en,
    output logic [SEG_W-1:0]  wr_seg,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              transfer_done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [15:0]       progress
);
    localparam int SC_W = $clog2(NUM_SEG + 1);
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, LOAD, CHECK, DONE, ERR} state_t;

    function automatic logic [15:0] seg_len(input int s);
        return SEG_LEN[s*16 +: 16];
    endfunction

    function automatic logic [2:0] seg_bytes(input int s);
        return SEG_BYTES[s*3 +: 3];
    endfunction

    function automatic logic [ADDR_W-1:0] seg_base(input int s);
        return SEG_BASE[s*ADDR_W +: ADDR_W];
    endfunction

    // First non-empty segment at or after 'from'; NUM_SEG when none remain
    function automatic logic [SC_W-1:0] first_seg(input int from);
        logic [SC_W-1:0] r;
        r = SC_W'(NUM_SEG);
        for (int i = NUM_SEG - 1; i >= 0; i--)
            if (i >= from && seg_len(i) != 16'd0) r = SC_W'(i);
        return r;
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input logic [2:0] n);
        return (n == 3'd1) ? {{24{v[7]}}, v[7:0]} :
               (n == 3'd2) ? {{16{v[15]}}, v[15:0]} :
               (n == 3'd3) ? {{8{v[23]}}, v[23:0]} : v;
    endfunction

    state_t            state_q, state_d;
    logic [SC_W-1:0]   seg_q, seg_d, nxt, first;
    int                cur;
    logic [15:0]       elem_q, elem_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       asm_q, asm_d, merged;
    logic [2:0]        nb;
    logic [15:0]       csum_q, csum_d;
    logic [7:0]        trl_lo_q, trl_lo_d;
    logic              trl_got_q, trl_got_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [15:0]       progress_q, progress_d;
    logic              wr_en_q, wr_en_d;
    logic [SEG_W-1:0]  wr_seg_q, wr_seg_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d, error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    assign busy = (state_q == SYNC) || (state_q == LOAD) || (state_q == CHECK);
    assign wr_en = wr_en_q;
    assign wr_seg = wr_seg_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign transfer_done = done_q;
    assign error = error_q;
    assign err_code = err_code_q;
    assign progress = progress_q;

    always_comb begin
        cur = (seg_q < SC_W'(NUM_SEG)) ? int'(seg_q) : 0;
        nb = seg_bytes(cur);
        merged = asm_q | (32'(rx_data) << {k_q, 3'b000});
        nxt = first_seg(cur + 1);
        first = first_seg(0);
        state_d = state_q;
        seg_d = seg_q;
        elem_d = elem_q;
        k_d = k_q;
        asm_d = asm_q;
        csum_d = csum_q;
        trl_lo_d = trl_lo_q;
        trl_got_d = trl_got_q;
        idle_d = (busy && !rx_ready) ? idle_q + IW'(1) : '0;
        progress_d = progress_q;
        wr_en_d = 1'b0;
        wr_seg_d = wr_seg_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d = done_q;
        error_d = error_q;
        err_code_d = err_code_q;
        if (busy && !rx_ready && idle_q == IW'(TIMEOUT_CYC - 1)) begin
            state_d = ERR;
            error_d = 1'b1;
            err_code_d = 2'd1;
            k_d = '0;
            asm_d = '0;
            idle_d = '0;
        end else if (rx_ready) begin
            case (state_q)
                IDLE: state_d = (rx_data == SYNC0) ? SYNC : IDLE;
                SYNC: begin
                    if (rx_data == SYNC1) begin
                        state_d = (first == SC_W'(NUM_SEG)) ? CHECK : LOAD;
                        seg_d = first;
                        elem_d = '0;
                        k_d = '0;
                        asm_d = '0;
                        csum_d = '0;
                        progress_d = '0;
                        trl_got_d = 1'b0;
                    end else if (rx_data != SYNC0) begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    csum_d = csum_q + {8'd0, rx_data};
                    progress_d = (progress_q == 16'hFFFF) ? progress_q : progress_q + 16'd1;
                    if (k_q == 2'(nb - 3'd1)) begin
                        k_d = '0;
                        asm_d = '0;
                        wr_en_d = 1'b1;
                        wr_seg_d = SEG_W'(cur);
                        wr_addr_d = seg_base(cur) + ADDR_W'(elem_q);
                        wr_data_d = sext(merged, nb);
                        elem_d = (elem_q + 16'd1 == seg_len(cur)) ? 16'd0 : elem_q + 16'd1;
                        seg_d = (elem_q + 16'd1 == seg_len(cur)) ? nxt : seg_q;
                        state_d = (elem_q + 16'd1 == seg_len(cur) && nxt == SC_W'(NUM_SEG)) ? CHECK : LOAD;
                    end else begin
                        k_d = k_q + 2'd1;
                        asm_d = merged;
                    end
                end
                CHECK: begin
                    if (!trl_got_q) begin
                        trl_lo_d = rx_data;
                        trl_got_d = 1'b1;
                    end else if ({rx_data, trl_lo_q} == csum_q) begin
                        state_d = DONE;
                        done_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                        err_code_d = 2'd2;
                    end
                end
                DONE, ERR: begin
                    if (rx_data == SYNC0) begin
                        state_d = SYNC;
                        done_d = 1'b0;
                        error_d = 1'b0;
                        err_code_d = 2'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            seg_q <= '0;
            elem_q <= '0;
            k_q <= '0;
            asm_q <= '0;
            csum_q <= '0;
            trl_lo_q <= '0;
            trl_got_q <= 1'b0;
            idle_q <= '0;
            progress_q <= '0;
            wr_en_q <= 1'b0;
            wr_seg_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q <= 1'b0;
            error_q <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q <= state_d;
            seg_q <= seg_d;
            elem_q <= elem_d;
            k_q <= k_d;
            asm_q <= asm_d;
            csum_q <= csum_d;
            trl_lo_q <= trl_lo_d;
            trl_got_q <= trl_got_d;
            idle_q <= idle_d;
            progress_q <= progress_d;
            wr_en_q <= wr_en_d;
            wr_seg_q <= wr_seg_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q <= done_d;
            error_q <= error_d;
            err_code_q <= err_code_d;
        end
    end
endmodule

// File: tb/tb_param_stream_loader.sv
// tb_param_stream_loader: random frames against a segment-map reference model of the loader
module tb_param_stream_loader;
    localparam int TO = 64;
    localparam int NSEG = 6;
    localparam int LEN [NSEG] = '{144, 16, 4608, 32, 8000, 10};
    localparam int NB [NSEG] = '{1, 4, 1, 4, 1, 4};
    localparam int BASE [NSEG] = '{0, 0, 144, 16, 0, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        wr_en, busy, transfer_done, error;
    logic [2:0]  wr_seg;
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  err_code;
    logic [15:0] progress;

    param_stream_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_seg(wr_seg), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .transfer_done(transfer_done), .error(error),
        .err_code(err_code), .progress(progress)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0]  pay [$];
    logic [47:0] exp_all [$];
    int          exp_end [$];
    logic [47:0] exp_q [$];
    logic [47:0] got_q [$];
    logic [15:0] csum_m;
    int          n_exp;
    int          w0;
    int          w1;
    logic [47:0] tmp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            got_q.push_back({wr_seg, wr_addr, wr_data});
            if (exp_q.size() == 0) check("wr_extra", 64'd1, 64'd0);
            else check("wr", 64'({wr_seg, wr_addr, wr_data}), 64'(exp_q.pop_front()));
        end
    end

    task automatic build_frame();
        int p;
        longint v;
        pay.delete();
        exp_all.delete();
        exp_end.delete();
        for (int s = 0; s < NSEG; s++)
            for (int i = 0; i < LEN[s] * NB[s]; i++) pay.push_back(8'($urandom));
        pay[0] = 8'hFF;
        pay[144] = 8'h78;
        pay[145] = 8'h56;
        pay[146] = 8'h34;
        pay[147] = 8'h12;
        csum_m = 16'd0;
        foreach (pay[i]) csum_m += {8'd0, pay[i]};
        p = 0;
        for (int s = 0; s < NSEG; s++) begin
            for (int e = 0; e < LEN[s]; e++) begin
                v = 0;
                for (int b = 0; b < NB[s]; b++) begin
                    v += longint'(pay[p]) << (8 * b);
                    p++;
                end
                if (NB[s] < 4 && v >= (longint'(1) << (8 * NB[s] - 1))) v -= longint'(1) << (8 * NB[s]);
                exp_all.push_back({3'(s), 13'(BASE[s] + e), 32'(v)});
                exp_end.push_back(p - 1);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat (($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0) @(negedge clk);
        rx_data = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input int n_pay, input logic [15:0] flip);
        logic [15:0] trl;
        exp_q.delete();
        n_exp = 0;
        foreach (exp_all[i])
            if (exp_end[i] < n_pay) begin
                exp_q.push_back(exp_all[i]);
                n_exp++;
            end
        w0 = got_q.size();
        send_byte(8'hA5);
        check("sync_status", {busy, transfer_done, error, err_code}, 5'b10000);
        send_byte(8'h5A);
        check("prog_clear", progress, 0);
        for (int i = 0; i < n_pay; i++) send_byte(pay[i]);
        if (n_pay == pay.size()) begin
            trl = csum_m ^ flip;
            send_byte(trl[7:0]);
            send_byte(trl[15:8]);
        end
    endtask

    task automatic check_writes();
        repeat (3) @(negedge clk);
        check("wr_count", 64'(got_q.size() - w0), 64'(n_exp));
        check("wr_missing", 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr", {wr_en, wr_seg, wr_addr, wr_data}, 0);
        check("rst_st", {busy, transfer_done, error, err_code, progress}, 0);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h00);
        check("pfx_idle", busy, 0);
        send_byte(8'hA5);
        check("pfx_sync", busy, 1);
        check("pfx_nowr", 64'(got_q.size()), 0);
        build_frame();
        send_frame(pay.size(), 16'h0000);
        check_writes();
        check("t1_writes", 64'(got_q.size() - w0), 12810);
        check("t1_prog", progress, 12984);
        check("t1_status", {busy, transfer_done, error, err_code}, 5'b01000);
        tmp = got_q[w0];
        check("t2_seg0", tmp, {3'd0, 13'd0, 32'hFFFFFFFF});
        tmp = got_q[w0 + 144];
        check("t2_seg1", tmp, {3'd1, 13'd0, 32'h12345678});
        build_frame();
        send_frame(pay.size(), 16'h0001);
        check_writes();
        check("t4_status", {busy, transfer_done, error, err_code}, 5'b00110);
        build_frame();
        send_frame(500, 16'h0000);
        repeat (TO - 2) @(negedge clk);
        check("t5_early", {busy, error}, 2'b10);
        repeat (4) @(negedge clk);
        check("t5_status", {busy, transfer_done, error, err_code}, 5'b00101);
        check("t5_prog", progress, 500);
        check_writes();
        build_frame();
        send_frame(pay.size(), 16'h0000);
        check_writes();
        check("t5_resume", {busy, transfer_done, error, err_code}, 5'b01000);
        build_frame();
        send_frame(300, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_wr", {wr_en, wr_seg, wr_addr, wr_data}, 0);
        check("t6_rst_st", {busy, transfer_done, error, err_code, progress}, 0);
        rst = 1'b0;
        w1 = got_q.size();
        repeat (10) @(negedge clk);
        check("t6_nowr", 64'(got_q.size() - w1), 0);
        check("t6_missing", 64'(exp_q.size()), 0);
        exp_q.delete();
        build_frame();
        send_frame(pay.size(), 16'h0000);
        check_writes();
        tmp = got_q[w0];
        check("t6_first", tmp[47:32], 0);
        check("t6_status", {busy, transfer_done, error, err_code}, 5'b01000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
